// File: rtl/aes_inv_key_sched.sv
// ---------------------------------------------------------------------------
// aes_inv_key_sched
//   Iterative AES-128 key schedule for the decrypt datapath. It walks forward
//   from the cipher key to round key 10, then walks backward and hands out
//   round keys 10 down to 0 over a valid/ready handshake. It keeps no key
//   store: each earlier round key is recomputed from the current one.
//
//   Parameters
//     SERIAL_SBOX  0: four S-boxes, one round step per cycle
//                  1: one time-shared S-box, four cycles per round step
//
//   Ports
//     clk       rising-edge clock
//     rst       asynchronous, active-high reset
//     start     begin a schedule (sampled only in IDLE)
//     key_in    cipher key, key_in[127:120] is byte 0
//     busy      high from the cycle after an accepted start until done
//     rk_out    current round key, same byte order as key_in
//     rk_round  round index of rk_out
//     rk_valid  rk_out / rk_round are valid
//     rk_ready  consumer accepts on rk_valid & rk_ready
//     done      one-cycle pulse after round key 0 is accepted
//
// aes_sbox
//   Shared byte-substitution unit. dec=0 gives the AES S-box, dec=1 its
//   inverse. Computed as GF(2^8) inversion plus the affine map instead of a
//   lookup table.
//
//   Ports
//     value   input byte
//     dec     0 = forward S-box, 1 = inverse S-box
//     result  substituted byte
// ---------------------------------------------------------------------------

module aes_sbox (
  input  logic [7:0] value,
  input  logic       dec,
  output logic [7:0] result
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse; it maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    if (dec) result = gf_inv(inv_affine(value));
    else     result = affine(gf_inv(value));
  end

endmodule

module aes_inv_key_sched #(
  parameter int SERIAL_SBOX = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_BWD  = 2'd3;  // serial variant only

  logic [1:0]  state;
  logic [1:0]  sub_cnt;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] bw3;          // w3 of the previous round key
  logic [31:0] sbox_word;
  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [3:0]  rcon_idx;
  logic [7:0]  rcon;
  logic        step_now;     // SubWord result is complete this cycle
  logic [127:0] fwd_next;
  logic [127:0] bwd_next;

  assign w0  = rk_out[127:96];
  assign w1  = rk_out[95:64];
  assign w2  = rk_out[63:32];
  assign w3  = rk_out[31:0];
  assign bw3 = w3 ^ w2;

  // Going forward SubWord uses the current w3; going backward it needs w3 of
  // the key being recovered, which is w3 ^ w2 of the current one.
  assign sbox_word = (state == S_FWD) ? w3 : bw3;
  assign rot_word  = {sbox_word[23:0], sbox_word[31:24]};

  // Forward step r-1 -> r uses Rcon[r]; backward step r -> r-1 also uses Rcon[r].
  assign rcon_idx = (state == S_FWD) ? rk_round + 4'd1 : rk_round;

  // NOTE: every path through a combinational case assigns the output (here via
  // default), otherwise the tool infers a latch to hold the old value.
  always_comb begin
    case (rcon_idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    logic [31:0] n0, n1, n2;
    n0 = w0 ^ sub_word ^ {rcon, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    fwd_next = {n0, n1, n2, w3 ^ n2};
  end

  assign bwd_next = {w0 ^ sub_word ^ {rcon, 24'h0}, w1 ^ w0, w2 ^ w1, bw3};

  generate
    if (SERIAL_SBOX == 0) begin : g_par
      for (genvar i = 0; i < 4; i++) begin : g_sb
        aes_sbox u_sbox (
          .value  (rot_word[8*i +: 8]),
          .dec    (1'b0),
          .result (sub_word[8*i +: 8])
        );
      end
      assign step_now = 1'b1;
    end else begin : g_ser
      logic [7:0]  sel_byte;
      logic [7:0]  sb_out;
      logic [23:0] hold;     // substituted bytes from sub-counts 0..2

      always_comb begin
        case (sub_cnt)
          2'd0:    sel_byte = rot_word[31:24];
          2'd1:    sel_byte = rot_word[23:16];
          2'd2:    sel_byte = rot_word[15:8];
          default: sel_byte = rot_word[7:0];
        endcase
      end

      aes_sbox u_sbox (
        .value  (sel_byte),
        .dec    (1'b0),
        .result (sb_out)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold <= '0;
        end else if (state == S_FWD || state == S_BWD) begin
          case (sub_cnt)
            2'd0:    hold[23:16] <= sb_out;
            2'd1:    hold[15:8]  <= sb_out;
            2'd2:    hold[7:0]   <= sb_out;
            default: ;
          endcase
        end
      end

      // The last byte goes straight from the S-box into the combine.
      assign sub_word = {hold, sb_out};
      assign step_now = (sub_cnt == 2'd3);
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      sub_cnt  <= 2'd0;
      rk_out   <= '0;
      rk_round <= 4'd0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The done cycle is still the tail of the previous schedule.
          if (start && !done) begin
            rk_out   <= key_in;
            rk_round <= 4'd0;
            busy     <= 1'b1;
            sub_cnt  <= 2'd0;
            state    <= S_FWD;
          end
        end
        S_FWD: begin
          if (SERIAL_SBOX != 0) sub_cnt <= sub_cnt + 2'd1;
          if (step_now) begin
            rk_out   <= fwd_next;
            rk_round <= rk_round + 4'd1;
            if (rk_round == 4'd9) begin
              rk_valid <= 1'b1;
              state    <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (rk_ready) begin
            if (rk_round == 4'd0) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_IDLE;
            end else if (SERIAL_SBOX == 0) begin
              rk_out   <= bwd_next;
              rk_round <= rk_round - 4'd1;
            end else begin
              rk_valid <= 1'b0;
              sub_cnt  <= 2'd0;
              state    <= S_BWD;
            end
          end
        end
        S_BWD: begin
          sub_cnt <= sub_cnt + 2'd1;
          if (step_now) begin
            rk_out   <= bwd_next;
            rk_round <= rk_round - 4'd1;
            rk_valid <= 1'b1;
            state    <= S_EMIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_key_sched
//   Directed bench for aes_inv_key_sched. One instance of each variant
//   (SERIAL_SBOX=0 and 1) shares rst, key_in and rk_ready; start is steered
//   to the instance selected by sel, and the observed outputs follow sel.
// ---------------------------------------------------------------------------

module tb_aes_inv_key_sched;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_ALT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] R10_SEQ  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] R10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sel;
  logic         rk_ready;
  logic [127:0] key_in;

  logic         start0, start1;
  logic         busy0, busy1, rk_valid0, rk_valid1, done0, done1;
  logic [127:0] rk_out0, rk_out1;
  logic [3:0]   rk_round0, rk_round1;

  logic         busy_o, rk_valid_o, done_o;
  logic [127:0] rk_out_o;
  logic [3:0]   rk_round_o;

  logic [127:0] exp_rk [0:10];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t0          = 0;

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  assign busy_o     = sel ? busy1     : busy0;
  assign rk_valid_o = sel ? rk_valid1 : rk_valid0;
  assign done_o     = sel ? done1     : done0;
  assign rk_out_o   = sel ? rk_out1   : rk_out0;
  assign rk_round_o = sel ? rk_round1 : rk_round0;

  aes_inv_key_sched #(.SERIAL_SBOX(0)) u_par (
    .clk      (clk),
    .rst      (rst),
    .start    (start0),
    .key_in   (key_in),
    .busy     (busy0),
    .rk_out   (rk_out0),
    .rk_round (rk_round0),
    .rk_valid (rk_valid0),
    .rk_ready (rk_ready),
    .done     (done0)
  );

  aes_inv_key_sched #(.SERIAL_SBOX(1)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .start    (start1),
    .key_in   (key_in),
    .busy     (busy1),
    .rk_out   (rk_out1),
    .rk_round (rk_round1),
    .rk_valid (rk_valid1),
    .rk_ready (rk_ready),
    .done     (done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input logic [127:0] key);
    key_in = key;
    start  = 1'b1;
    t0     = cyc;
    tick;
    start  = 1'b0;
    check("busy_after_start", busy_o, 1);
  endtask

  // Collect round keys 10..0 and finish on the done cycle.
  //   lat      cycles from start to first rk_valid (-1: skip)
  //   gap      invalid cycles between consecutive keys
  //   full     compare every key against exp_rk, else only rounds 10 and 0
  //   done_at  cycles from start to done (-1: skip)
  task automatic walk(input logic [127:0] key, input int lat, input int gap,
                      input bit rand_ready, input bit full,
                      input logic [127:0] r10, input int done_at);
    int           n;
    logic [127:0] h_out;
    logic [3:0]   h_rnd;
    n = 0;
    while (!rk_valid_o && n < 200) begin
      tick;
      n++;
    end
    if (lat >= 0) check("first_valid_latency", cyc - t0, lat);
    for (int r = 10; r >= 0; r--) begin
      n = 0;
      while (!rk_valid_o && n < 20) begin
        tick;
        n++;
      end
      if (r < 10) check("key_gap", n, gap);
      check("rk_valid", rk_valid_o, 1);
      check("rk_round", rk_round_o, r);
      if (full)         check("rk_out", rk_out_o, exp_rk[r]);
      else if (r == 10) check("rk_out_r10", rk_out_o, r10);
      else if (r == 0)  check("rk_out_r0", rk_out_o, key);
      if (rand_ready) begin
        n = 0;
        while (n < 16) begin
          rk_ready = 1'($urandom_range(0, 1));
          if (rk_ready) break;
          h_out = rk_out_o;
          h_rnd = rk_round_o;
          tick;
          check("stall_rk_out", rk_out_o, h_out);
          check("stall_rk_round", rk_round_o, h_rnd);
          check("stall_rk_valid", rk_valid_o, 1);
          n++;
        end
      end
      rk_ready = 1'b1;
      tick;
    end
    check("done_pulse", done_o, 1);
    check("busy_clear", busy_o, 0);
    check("valid_clear", rk_valid_o, 0);
    check("rk_out_keeps_key", rk_out_o, key);
    if (done_at >= 0) check("done_cycle", cyc - t0, done_at);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    exp_rk[0]  = KEY_FIPS;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst      = 1'b0;
    start    = 1'b0;
    sel      = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;
    #1 rst = 1'b1;
    #1;
    check("reset_rk_out_par", rk_out0, 0);
    check("reset_round_par", rk_round0, 0);
    check("reset_valid_par", rk_valid0, 0);
    check("reset_busy_par", busy0, 0);
    check("reset_done_par", done0, 0);
    check("reset_rk_out_ser", rk_out1, 0);
    check("reset_valid_ser", rk_valid1, 0);
    check("reset_busy_ser", busy1, 0);
    tick;
    tick;
    rst = 1'b0;
    tick;

    // Parallel variant, consumer always ready.
    sel = 1'b0;
    rk_ready = 1'b1;
    launch(KEY_FIPS);
    walk(KEY_FIPS, 11, 0, 1'b0, 1'b1, exp_rk[10], 22);
    tick;
    check("done_one_cycle", done_o, 0);

    // Parallel variant, random back-pressure.
    rk_ready = 1'b0;
    launch(KEY_FIPS);
    walk(KEY_FIPS, 11, 0, 1'b1, 1'b1, exp_rk[10], -1);
    tick;

    // Serial variant, always ready, then random back-pressure.
    sel = 1'b1;
    rk_ready = 1'b1;
    launch(KEY_FIPS);
    walk(KEY_FIPS, 41, 4, 1'b0, 1'b1, exp_rk[10], 92);
    tick;
    check("ser_done_one_cycle", done_o, 0);
    rk_ready = 1'b0;
    launch(KEY_FIPS);
    walk(KEY_FIPS, 41, 4, 1'b1, 1'b1, exp_rk[10], -1);
    tick;

    // start with another key during FWD and during EMIT is ignored.
    sel = 1'b0;
    rk_ready = 1'b0;
    launch(KEY_FIPS);
    key_in = KEY_ALT;
    start  = 1'b1;
    tick;
    tick;
    start  = 1'b0;
    n = 0;
    while (!rk_valid_o && n < 50) begin
      tick;
      n++;
    end
    check("ignore_fwd_latency", cyc - t0, 11);
    check("ignore_fwd_r10", rk_out_o, exp_rk[10]);
    start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    check("ignore_emit_r10", rk_out_o, exp_rk[10]);
    check("ignore_emit_round", rk_round_o, 10);
    check("ignore_emit_busy", busy_o, 1);
    walk(KEY_FIPS, -1, 0, 1'b0, 1'b1, exp_rk[10], -1);
    tick;

    // Reset while round 6 is on offer.
    rk_ready = 1'b1;
    launch(KEY_FIPS);
    n = 0;
    while (!(rk_valid_o && rk_round_o == 4'd6) && n < 60) begin
      tick;
      n++;
    end
    check("reached_round6", rk_round_o, 6);
    rst = 1'b1;
    #1;
    check("midrst_rk_out", rk_out_o, 0);
    check("midrst_round", rk_round_o, 0);
    check("midrst_valid", rk_valid_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    tick;
    tick;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (rk_valid_o || done_o || busy_o) bad++;
    end
    check("quiet_after_reset", bad, 0);
    launch(KEY_SEQ);
    walk(KEY_SEQ, 11, 0, 1'b0, 1'b0, R10_SEQ, 22);
    tick;

    // All-zero key; start held from the done cycle is taken one cycle later.
    launch('0);
    walk('0, 11, 0, 1'b0, 1'b0, R10_ZERO, 22);
    key_in = '0;
    start  = 1'b1;
    tick;
    check("start_on_done_ignored", busy_o, 0);
    t0 = cyc;
    tick;
    start = 1'b0;
    check("start_after_done_taken", busy_o, 1);
    walk('0, 11, 0, 1'b0, 1'b0, R10_ZERO, 22);
    tick;
    check("final_done_clear", done_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
